// File: rtl/cart_sdram_loader.sv
// Streams ioctl download bytes through a small FIFO into SDRAM and shares the SDRAM
// port with the core bus; the core only sees the port while no download is active.
module cart_sdram_loader #(
    parameter logic [7:0]  INDEX      = 8'h01,
    parameter logic [22:0] BASE_ADDR  = 23'h000000,
    parameter logic [24:0] ADDR_LIMIT = 25'h040000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [22:0] core_addr,
    input  logic [7:0]  core_din,
    input  logic        core_we,
    input  logic        core_rd,
    output logic [7:0]  core_dout,
    output logic        core_ready,
    output logic [22:0] sdram_addr,
    output logic [7:0]  sdram_din,
    output logic        sdram_we,
    output logic        sdram_rd,
    input  logic [7:0]  sdram_dout,
    input  logic        sdram_ready,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_overflow,
    output logic [24:0] load_count
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {StIdle, StArm, StWrite, StDone} state_e;
    state_e state_q, state_d;

    logic [30:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full;
    logic        match, match_q, accept, push, pop, arm_clear;
    logic [22:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [24:0] count_q;
    logic        overflow_q;

    assign match      = ioctl_download && (ioctl_index == INDEX);
    assign accept     = ioctl_wr && match && (ioctl_addr < ADDR_LIMIT);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty when the index bits coincide.
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = accept && !fifo_full;
    assign pop        = (state_q == StArm) && !fifo_empty;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {BASE_ADDR + ioctl_addr[22:0], ioctl_dout};
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (match && !match_q) begin
                    state_d   = StArm;
                    arm_clear = 1'b1;
                end
            end
            StArm: begin
                if (!fifo_empty) begin
                    state_d = StWrite;
                end else if (!ioctl_download) begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                if (sdram_ready) begin
                    state_d = StArm;
                end
            end
            StDone: begin
                // A download restarting right at the end continues the same load.
                state_d = match ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            match_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q               <= rd_ptr_q + PTR_ONE;
                {wr_addr_q, wr_data_q} <= fifo_mem[rd_ptr_q[PW-1:0]];
            end
            if (arm_clear) begin
                count_q <= '0;
            end else if ((state_q == StWrite) && sdram_ready) begin
                count_q <= count_q + 25'd1;
            end
            if (arm_clear) begin
                overflow_q <= 1'b0;
            end
            if (accept && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        sdram_addr = wr_addr_q;
        sdram_din  = wr_data_q;
        sdram_we   = (state_q == StWrite);
        sdram_rd   = 1'b0;
        core_dout  = 8'h00;
        core_ready = 1'b0;
        if (state_q == StIdle) begin
            sdram_addr = core_addr;
            sdram_din  = core_din;
            sdram_we   = core_we;
            sdram_rd   = core_rd;
            core_dout  = sdram_dout;
            core_ready = sdram_ready;
        end
    end

    assign load_busy     = (state_q == StArm) || (state_q == StWrite);
    assign load_done     = (state_q == StDone);
    assign load_overflow = overflow_q;
    assign load_count    = count_q;

endmodule

// File: tb/tb_cart_sdram_loader.sv
// Bench for cart_sdram_loader: per-cycle comparison against a queue-based model of the
// loader, an SDRAM responder with programmable latency, and directed literal checks.
`timescale 1ns/1ps
module tb_cart_sdram_loader;
    localparam logic [22:0] BASE  = 23'h7FFFFE;
    localparam logic [24:0] LIMIT = 25'h040000;
    localparam int PIdle = 0, PArm = 1, PWr = 2, PDone = 3;

    logic        clk_sys = 0, reset_n = 0;
    logic        ioctl_download = 0, ioctl_wr = 0;
    logic [7:0]  ioctl_index = 0, ioctl_dout = 0;
    logic [24:0] ioctl_addr = 0;
    logic [22:0] core_addr = 0;
    logic [7:0]  core_din = 0;
    logic        core_we = 0, core_rd = 0;
    logic [7:0]  core_dout, sdram_din;
    logic        core_ready, sdram_we, sdram_rd;
    logic [22:0] sdram_addr;
    logic [7:0]  sdram_dout = 0;
    logic        sdram_ready = 0;
    logic        load_busy, load_done, load_overflow;
    logic [24:0] load_count;

    cart_sdram_loader #(.INDEX(8'h01), .BASE_ADDR(BASE), .ADDR_LIMIT(LIMIT), .FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .core_addr(core_addr), .core_din(core_din),
        .core_we(core_we), .core_rd(core_rd), .core_dout(core_dout), .core_ready(core_ready),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_we(sdram_we),
        .sdram_rd(sdram_rd), .sdram_dout(sdram_dout), .sdram_ready(sdram_ready),
        .load_busy(load_busy), .load_done(load_done), .load_overflow(load_overflow),
        .load_count(load_count)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int total = 0, bad = 0;
    int done_cnt = 0, we_seen = 0, rdy_in_load = 0;
    int lat = 3, rcnt = 0;
    int d0, w0, r0;
    logic [7:0] mem [logic [22:0]];

    // Model: spec-level view of the loader phase, accepted-byte queue and counters.
    int          ph = PIdle;
    logic [30:0] q[$];
    logic [30:0] cur = 0;
    logic [24:0] m_count = 0;
    logic        m_ovf = 0, m_prev = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_mem(input logic [22:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic model_step();
        logic m, acc;
        int sz;
        logic [22:0] a;
        m   = ioctl_download && (ioctl_index == 8'h01);
        acc = ioctl_wr && m && (ioctl_addr < LIMIT);
        sz  = q.size();
        a   = BASE + ioctl_addr[22:0];
        case (ph)
            PIdle: if (m && !m_prev) begin ph = PArm; m_count = 0; m_ovf = 0; end
            PArm: begin
                if (sz > 0) begin cur = q.pop_front(); ph = PWr; end
                else if (!ioctl_download) ph = PDone;
            end
            PWr: if (sdram_ready) begin m_count = m_count + 25'd1; ph = PArm; end
            default: ph = m ? PArm : PIdle;
        endcase
        if (acc) begin
            if (sz >= 4) m_ovf = 1'b1;
            else q.push_back({a, ioctl_dout});
        end
        m_prev = m;
    endtask

    initial forever begin
        @(posedge clk_sys or negedge reset_n);
        if (!reset_n) begin
            ph = PIdle; q.delete(); m_count = 0; m_ovf = 0; m_prev = 0;
        end else begin
            model_step();
        end
    end

    // Compare process: outputs are combinational on state, so check mid-cycle.
    initial forever begin
        logic [4:0] ctl;
        @(negedge clk_sys);
        ctl = {sdram_we, sdram_rd, core_ready, load_busy, load_done};
        chk("count", 64'(load_count), 64'(m_count));
        chk("overflow", 64'(load_overflow), 64'(m_ovf));
        case (ph)
            PIdle: begin
                chk("idle_ctl", 64'(ctl), 64'({core_we, core_rd, sdram_ready, 2'b00}));
                chk("idle_addr", 64'(sdram_addr), 64'(core_addr));
                chk("idle_data", 64'({sdram_din, core_dout}), 64'({core_din, sdram_dout}));
            end
            PArm: chk("arm_ctl", 64'({ctl, core_dout}), 64'({5'b00010, 8'h00}));
            PWr: begin
                chk("wr_ctl", 64'({ctl, core_dout}), 64'({5'b10010, 8'h00}));
                chk("wr_addr", 64'(sdram_addr), 64'(cur[30:8]));
                chk("wr_din", 64'(sdram_din), 64'(cur[7:0]));
            end
            default: chk("done_ctl", 64'({ctl, core_dout}), 64'({5'b00001, 8'h00}));
        endcase
        if (load_done) done_cnt++;
        if (sdram_we) we_seen++;
        if (load_busy && core_ready) rdy_in_load++;
    end

    // SDRAM responder: one-cycle ready pulse after lat cycles of a held request.
    initial forever begin
        @(posedge clk_sys);
        #2;
        if (!reset_n) begin
            sdram_ready = 0; rcnt = 0;
        end else if (sdram_ready) begin
            sdram_ready = 0; rcnt = 0;
        end else if (sdram_we || sdram_rd) begin
            rcnt++;
            if (rcnt >= lat) begin
                sdram_ready = 1;
                if (sdram_we) mem[sdram_addr] = sdram_din;
                else sdram_dout = 8'($urandom);
            end
        end else begin
            rcnt = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin tick(); n++; end
        chk(nm, 64'(done_cnt != start), 64'(1));
        repeat (4) tick();
    endtask

    logic [7:0] t1b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        repeat (2) tick();
        chk("rst_count", 64'(load_count), 64'(0));
        chk("rst_flags", 64'({load_busy, load_done, load_overflow, sdram_we}), 64'(0));
        reset_n = 1;
        repeat (2) tick();

        // 4 bytes with random gaps; BASE near the top checks the 23-bit wrap.
        mem.delete(); lat = 3; d0 = done_cnt;
        ioctl_index = 8'h01; ioctl_download = 1; tick();
        for (int i = 0; i < 4; i++) begin
            send(25'(i), t1b[i]);
            repeat ($urandom_range(0, 2)) tick();
        end
        ioctl_download = 0;
        wait_done("t1_done", 200);
        chk("t1_count", 64'(load_count), 64'(4));
        chk("t1_mem0", 64'(rd_mem(23'h7FFFFE)), 64'(8'hAA));
        chk("t1_mem1", 64'(rd_mem(23'h7FFFFF)), 64'(8'hBB));
        chk("t1_mem2", 64'(rd_mem(23'h000000)), 64'(8'hCC));
        chk("t1_mem3", 64'(rd_mem(23'h000001)), 64'(8'hDD));
        chk("t1_pulses", 64'(done_cnt - d0), 64'(1));

        // Back-to-back burst of 8 against a slow SDRAM: 4 queued + 1 popped survive.
        lat = 10; ioctl_download = 1;
        for (int i = 0; i < 8; i++) send(25'(i), 8'(8'h10 + i));
        ioctl_download = 0;
        wait_done("t2_done", 300);
        chk("t2_count", 64'(load_count), 64'(5));
        chk("t2_ovf", 64'(load_overflow), 64'(1));

        // Byte exactly at the limit is discarded.
        lat = 2; d0 = done_cnt; w0 = we_seen;
        ioctl_download = 1; tick();
        send(25'h040000, 8'h55); tick();
        ioctl_download = 0;
        wait_done("t3_done", 100);
        chk("t3_count", 64'(load_count), 64'(0));
        chk("t3_ovf", 64'(load_overflow), 64'(0));
        chk("t3_no_we", 64'(we_seen - w0), 64'(0));
        chk("t3_pulses", 64'(done_cnt - d0), 64'(1));

        // Download falls during the second write; core read held throughout.
        mem.delete(); lat = 6; r0 = rdy_in_load;
        core_rd = 1; core_addr = 23'h000777;
        ioctl_download = 1; tick();
        send(25'd10, 8'h31);
        repeat (8) tick();
        send(25'd11, 8'h32);
        send(25'd12, 8'h33);
        ioctl_download = 0;
        wait_done("t4_done", 200);
        core_rd = 0; tick();
        chk("t4_count", 64'(load_count), 64'(3));
        chk("t4_mem", 64'({rd_mem(23'd8), rd_mem(23'd9), rd_mem(23'd10)}), 64'(24'h313233));
        chk("t4_no_core_ready", 64'(rdy_in_load - r0), 64'(0));

        // Idle core read passthrough.
        lat = 3; repeat (3) tick();
        core_addr = 23'h001234; core_rd = 1; #1;
        chk("t5_rd", 64'({sdram_rd, sdram_we}), 64'(2'b10));
        chk("t5_addr", 64'(sdram_addr), 64'(23'h001234));
        for (int n = 0; n < 20; n++) begin
            tick(); #2;
            if (core_ready) break;
        end
        chk("t5_ready", 64'(core_ready), 64'(1));
        chk("t5_dout", 64'(core_dout), 64'(sdram_dout));
        core_rd = 0; tick();

        // Reset mid-write with bytes still queued, then a clean download.
        lat = 8; ioctl_download = 1; tick();
        send(25'd5, 8'h61); send(25'd6, 8'h62); send(25'd7, 8'h63);
        tick();
        chk("t6_we_before", 64'(sdram_we), 64'(1));
        @(posedge clk_sys); #4;
        reset_n = 0; ioctl_download = 0; #1;
        chk("t6_we_async", 64'({sdram_we, load_busy}), 64'(0));
        tick(); tick();
        reset_n = 1; tick();
        mem.delete(); lat = 2; ioctl_download = 1; tick();
        send(25'd20, 8'h71); send(25'd21, 8'h72); send(25'd22, 8'h73);
        ioctl_download = 0;
        wait_done("t6_done", 200);
        chk("t6_count", 64'(load_count), 64'(3));
        chk("t6_mem", 64'({rd_mem(23'd18), rd_mem(23'd19), rd_mem(23'd20)}), 64'(24'h717273));

        // Randomized downloads, index mismatches, limit crossings and core traffic.
        for (int it = 0; it < 40; it++) begin
            int nb;
            logic [24:0] a;
            lat = $urandom_range(1, 5);
            ioctl_index = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h01;
            nb = $urandom_range(1, 10);
            a = ($urandom_range(0, 4) == 0) ? 25'h03FFFC : 25'($urandom_range(0, 1000));
            core_we = ($urandom_range(0, 1) != 0);
            core_rd = !core_we && ($urandom_range(0, 1) != 0);
            core_addr = 23'($urandom); core_din = 8'($urandom);
            ioctl_download = 1; tick();
            for (int i = 0; i < nb; i++) begin
                ioctl_wr = ($urandom_range(0, 3) != 0);
                ioctl_addr = a; ioctl_dout = 8'($urandom);
                if (ioctl_wr) a = a + 25'd1;
                tick();
                ioctl_wr = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
            ioctl_download = 0;
            if (ioctl_index == 8'h01) wait_done("rnd_done", 400);
            else repeat (5) tick();
            core_we = 0; core_rd = 0; tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
